// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants and the immediate-format helper
// for the registered instruction-decode stage.
package id_stage_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] ZERO_WORD     = 32'h0;
  localparam logic [4:0]  ZERO_REG_ADDR = 5'd0;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SH,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  function automatic logic [31:0] imm_gen(
    input logic [31:0] i,
    input imm_sel_e    s
  );
    logic [31:0] r;
    r = ZERO_WORD;
    unique case (s)
      IMM_I:  r = {{20{i[31]}}, i[31:20]};
      IMM_SH: r = {27'b0, i[24:20]};
      IMM_S:  r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:  r = {{19{i[31]}}, i[31], i[7],
                   i[30:25], i[11:8], 1'b0};
      IMM_U:  r = {i[31:12], 12'b0};
      IMM_J:  r = {{11{i[31]}}, i[31], i[19:12],
                   i[20], i[30:21], 1'b0};
      default: r = ZERO_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_stage_pipe_decode.sv
// Combinational RV32I/RV32E decoder: register fields,
// immediate, load flag and illegal-encoding flag.
module id_decode
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [31:0]           ins_i,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       imm_o,
  output logic                  uses_rs1_o,
  output logic                  uses_rs2_o,
  output logic                  is_load_o,
  output logic                  illegal_o
);

  localparam bit RV32E = (REG_ADDR_W < 5);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       u1, u2, urd, ld, bad;
  imm_sel_e   sel;

  assign opc = ins_i[6:0];
  assign f3  = ins_i[14:12];
  assign f7  = ins_i[31:25];

  always_comb begin
    u1  = 1'b0;
    u2  = 1'b0;
    urd = 1'b0;
    ld  = 1'b0;
    bad = 1'b0;
    sel = IMM_NONE;
    unique case (1'b1)
      (opc == OPC_LUI) || (opc == OPC_AUIPC): begin
        urd = 1'b1;
        sel = IMM_U;
      end
      opc == OPC_JAL: begin
        urd = 1'b1;
        sel = IMM_J;
      end
      opc == OPC_JALR: begin
        u1  = 1'b1;
        urd = 1'b1;
        sel = IMM_I;
        bad = (f3 != F3_ADD);
      end
      opc == OPC_BRANCH: begin
        u1  = 1'b1;
        u2  = 1'b1;
        sel = IMM_B;
        bad = (f3 == F3_SLT) || (f3 == F3_SLTU);
      end
      opc == OPC_LOAD: begin
        u1  = 1'b1;
        urd = 1'b1;
        ld  = 1'b1;
        sel = IMM_I;
        bad = !((f3 == F3_LB) || (f3 == F3_LH) ||
                (f3 == F3_LW) || (f3 == F3_LBU) ||
                (f3 == F3_LHU));
      end
      opc == OPC_STORE: begin
        u1  = 1'b1;
        u2  = 1'b1;
        sel = IMM_S;
        bad = (f3 > F3_LW);
      end
      opc == OPC_OP_IMM: begin
        u1  = 1'b1;
        urd = 1'b1;
        sel = IMM_I;
        if (f3 == F3_SLL) begin
          sel = IMM_SH;
          bad = (f7 != F7_BASE);
        end else if (f3 == F3_SR) begin
          sel = IMM_SH;
          bad = (f7 != F7_BASE) && (f7 != F7_ALT);
        end
      end
      opc == OPC_OP: begin
        u1  = 1'b1;
        u2  = 1'b1;
        urd = 1'b1;
        bad = !((f7 == F7_BASE) ||
                ((f7 == F7_ALT) &&
                 ((f3 == F3_ADD) || (f3 == F3_SR))));
      end
      default: bad = 1'b1;
    endcase
    // RV32E has only x0-x15: bit 4 of a used field traps
    if (RV32E)
      bad = bad || (u1 && ins_i[19]) ||
            (u2 && ins_i[24]) || (urd && ins_i[11]);
  end

  assign illegal_o  = bad;
  assign is_load_o  = ld && !bad;
  assign uses_rs1_o = u1 && !bad;
  assign uses_rs2_o = u2 && !bad;

  assign rs1_o = uses_rs1_o ? ins_i[15 +: REG_ADDR_W] : '0;
  assign rs2_o = uses_rs2_o ? ins_i[20 +: REG_ADDR_W] : '0;
  assign rd_o  = (urd && !bad) ? ins_i[7 +: REG_ADDR_W] : '0;

  assign imm_o = bad ? '0
               : XLEN'($signed(imm_gen(ins_i, sel)));

endmodule

// File: rtl/id_stage_pipe.sv
// Registered ID stage: one output slot with valid/ready,
// a load-use bubble and flush.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          REG_ADDR_W     = 5,
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ins_valid_i,
  output logic                  ins_ready_o,
  input  logic [31:0]           ins_i,
  input  logic [XLEN-1:0]       ins_addr_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [31:0]           ins_o,
  output logic [XLEN-1:0]       ins_addr_o,
  output logic [REG_ADDR_W-1:0] reg1_rd_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_rd_addr_o,
  output logic [REG_ADDR_W-1:0] reg_wr_addr_o,
  output logic [XLEN-1:0]       imm_o,
  output logic                  is_load_o,
  output logic                  illegal_o
);

  logic [REG_ADDR_W-1:0] d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0]       d_imm;
  logic                  d_u1, d_u2, d_ld, d_ill;

  id_decode #(
    .XLEN      (XLEN),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_dec (
    .ins_i     (ins_i),
    .rs1_o     (d_rs1),
    .rs2_o     (d_rs2),
    .rd_o      (d_rd),
    .imm_o     (d_imm),
    .uses_rs1_o(d_u1),
    .uses_rs2_o(d_u2),
    .is_load_o (d_ld),
    .illegal_o (d_ill)
  );

  logic                  valid_q, valid_d, load_en;
  logic [31:0]           ins_q;
  logic [XLEN-1:0]       addr_q, imm_q;
  logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic                  ld_q, ill_q;
  logic                  slot_free, hazard, xfer;

  assign slot_free = !valid_q || ex_ready_i;

  assign hazard = (LOAD_USE_STALL != 0) &&
                  valid_q && ld_q && ex_ready_i &&
                  (rd_q != ZERO_REG_ADDR[REG_ADDR_W-1:0]) &&
                  ((d_u1 && (d_rs1 == rd_q)) ||
                   (d_u2 && (d_rs2 == rd_q)));

  assign ins_ready_o = flush_i || (slot_free && !hazard);
  assign xfer        = ins_valid_i && ins_ready_o;

  always_comb begin
    valid_d = valid_q;
    load_en = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d = 1'b1;
      load_en = 1'b1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
      addr_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      ld_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_en) begin
        ins_q  <= ins_i;
        addr_q <= ins_addr_i;
        rs1_q  <= d_rs1;
        rs2_q  <= d_rs2;
        rd_q   <= d_rd;
        imm_q  <= d_imm;
        ld_q   <= d_ld;
        ill_q  <= d_ill;
      end
    end
  end

  assign ex_valid_o     = valid_q;
  assign ins_o          = ins_q;
  assign ins_addr_o     = addr_q;
  assign reg1_rd_addr_o = rs1_q;
  assign reg2_rd_addr_o = rs2_q;
  assign reg_wr_addr_o  = rd_q;
  assign imm_o          = imm_q;
  assign is_load_o      = ld_q;
  assign illegal_o      = ill_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized bench for id_stage_pipe: three configurations
// share one stimulus stream, each tracked by its own model.
module tb_id_stage_pipe;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic [31:0] ins = 32'h0;
  logic [31:0] addr = 32'h0;

  always #5 clk = ~clk;

  logic        rdy[N], ev[N], ld[N], ill[N];
  logic [31:0] io[N], ao[N], im[N];
  logic [4:0]  r1[N], r2[N], rw[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int RW = (g == 2) ? 4 : 5;
    localparam int LS = (g == 1) ? 0 : 1;
    logic [RW-1:0] a1, a2, aw;
    logic          w_rdy, w_ev, w_ld, w_ill;
    logic [31:0]   w_io, w_ao, w_im;

    id_stage_pipe #(
      .XLEN          (32),
      .REG_ADDR_W    (RW),
      .LOAD_USE_STALL(LS)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ins_valid_i   (ins_valid),
      .ins_ready_o   (w_rdy),
      .ins_i         (ins),
      .ins_addr_i    (addr),
      .flush_i       (flush),
      .ex_valid_o    (w_ev),
      .ex_ready_i    (ex_ready),
      .ins_o         (w_io),
      .ins_addr_o    (w_ao),
      .reg1_rd_addr_o(a1),
      .reg2_rd_addr_o(a2),
      .reg_wr_addr_o (aw),
      .imm_o         (w_im),
      .is_load_o     (w_ld),
      .illegal_o     (w_ill)
    );

    assign rdy[g] = w_rdy;
    assign ev[g]  = w_ev;
    assign io[g]  = w_io;
    assign ao[g]  = w_ao;
    assign im[g]  = w_im;
    assign ld[g]  = w_ld;
    assign ill[g] = w_ill;
    assign r1[g]  = 5'(a1);
    assign r2[g]  = 5'(a2);
    assign rw[g]  = 5'(aw);
  end

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ld;
    logic        ill;
  } dec_t;

  int tests = 0;
  int fails = 0;

  int   mrw[N] = '{5, 5, 4};
  int   mls[N] = '{1, 0, 1};
  logic mv[N];
  logic [31:0] mi[N], ma[N];
  dec_t md[N];
  logic last_rdy[N];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference decode written from the ISA field layout
  function automatic dec_t ref_dec(input logic [31:0] x,
                                   input int rwid);
    dec_t d;
    logic [31:0] sx;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    bit hrd, hr1, hr2, ok, isld;
    logic [31:0] imm;
    op = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
    sx = x[31] ? 32'hFFFF_FFFF : 32'h0;
    hrd = 0; hr1 = 0; hr2 = 0; ok = 1; isld = 0;
    imm = 32'h0;
    case (op)
      7'h37, 7'h17: begin
        hrd = 1; imm = x & 32'hFFFF_F000;
      end
      7'h6F: begin
        hrd = 1;
        imm = (sx << 20) | (32'(x[19:12]) << 12) |
              (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
      end
      7'h67: begin
        hrd = 1; hr1 = 1; ok = (f3 == 0);
        imm = (sx << 12) | 32'(x[31:20]);
      end
      7'h63: begin
        hr1 = 1; hr2 = 1; ok = !(f3 == 2 || f3 == 3);
        imm = (sx << 12) | (32'(x[7]) << 11) |
              (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
      end
      7'h03: begin
        hrd = 1; hr1 = 1; isld = 1;
        ok = (f3 == 0 || f3 == 1 || f3 == 2 ||
              f3 == 4 || f3 == 5);
        imm = (sx << 12) | 32'(x[31:20]);
      end
      7'h23: begin
        hr1 = 1; hr2 = 1; ok = (f3 <= 2);
        imm = (sx << 12) | (32'(x[31:25]) << 5) |
              32'(x[11:7]);
      end
      7'h13: begin
        hrd = 1; hr1 = 1;
        if (f3 == 1) begin
          ok = (f7 == 0); imm = 32'(x[24:20]);
        end else if (f3 == 5) begin
          ok = (f7 == 0 || f7 == 7'h20);
          imm = 32'(x[24:20]);
        end else begin
          imm = (sx << 12) | 32'(x[31:20]);
        end
      end
      7'h33: begin
        hrd = 1; hr1 = 1; hr2 = 1;
        ok = (f7 == 0) ||
             (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end
      default: ok = 0;
    endcase
    if (rwid == 4 && ((hrd && x[11:7] >= 16) ||
        (hr1 && x[19:15] >= 16) || (hr2 && x[24:20] >= 16)))
      ok = 0;
    d = '0;
    if (!ok) begin
      d.ill = 1'b1;
    end else begin
      d.rd  = hrd ? x[11:7] : 5'd0;
      d.rs1 = hr1 ? x[19:15] : 5'd0;
      d.rs2 = hr2 ? x[24:20] : 5'd0;
      d.imm = imm;
      d.ld  = isld;
    end
    return d;
  endfunction

  function automatic logic exp_ready(input int k);
    dec_t d;
    logic free, haz;
    d    = ref_dec(ins, mrw[k]);
    free = !mv[k] || ex_ready;
    // unused fields decode to 0 and rd is nonzero here
    haz  = (mls[k] != 0) && mv[k] && md[k].ld &&
           md[k].rd != 0 && ex_ready &&
           (d.rs1 == md[k].rd || d.rs2 == md[k].rd);
    return flush || (free && !haz);
  endfunction

  task automatic cmp_out(input int k);
    chk($sformatf("u%0d.ex_valid", k), 32'(ev[k]), 32'(mv[k]));
    if (mv[k]) begin
      chk($sformatf("u%0d.ins", k), io[k], mi[k]);
      chk($sformatf("u%0d.addr", k), ao[k], ma[k]);
      chk($sformatf("u%0d.rs1", k), 32'(r1[k]), 32'(md[k].rs1));
      chk($sformatf("u%0d.rs2", k), 32'(r2[k]), 32'(md[k].rs2));
      chk($sformatf("u%0d.rd", k), 32'(rw[k]), 32'(md[k].rd));
      chk($sformatf("u%0d.imm", k), im[k], md[k].imm);
      chk($sformatf("u%0d.is_load", k), 32'(ld[k]), 32'(md[k].ld));
      chk($sformatf("u%0d.illegal", k), 32'(ill[k]), 32'(md[k].ill));
    end
  endtask

  task automatic step(input logic v, input logic [31:0] x,
                      input logic f, input logic er);
    logic nv[N];
    logic lo[N];
    logic er_exp;
    @(negedge clk);
    ins_valid = v; ins = x; flush = f; ex_ready = er;
    addr = $urandom;
    #1;
    for (int k = 0; k < N; k++) begin
      er_exp = exp_ready(k);
      if (v) chk($sformatf("u%0d.ins_ready", k),
                 32'(rdy[k]), 32'(er_exp));
      last_rdy[k] = rdy[k];
      lo[k] = 1'b0;
      if (f) nv[k] = 1'b0;
      else if (v && er_exp) begin nv[k] = 1'b1; lo[k] = 1'b1; end
      else if (!mv[k] || er) nv[k] = 1'b0;
      else nv[k] = mv[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      mv[k] = nv[k];
      if (lo[k]) begin
        mi[k] = x; ma[k] = addr; md[k] = ref_dec(x, mrw[k]);
      end
      cmp_out(k);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s.u%0d.ex_valid", tag, k), 32'(ev[k]), 0);
      chk($sformatf("%s.u%0d.ins", tag, k), io[k], 0);
      chk($sformatf("%s.u%0d.addr", tag, k), ao[k], 0);
      chk($sformatf("%s.u%0d.regs", tag, k),
          32'({r1[k], r2[k], rw[k]}), 0);
      chk($sformatf("%s.u%0d.imm", tag, k), im[k], 0);
      chk($sformatf("%s.u%0d.flags", tag, k), 32'({ld[k], ill[k]}), 0);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0; mi[k] = 0; ma[k] = 0; md[k] = '0;
    end
  endtask

  function automatic logic [31:0] gen_ins();
    logic [31:0] x;
    logic [6:0]  op;
    x = $urandom;
    case ($urandom_range(0, 11))
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;
      3: op = 7'h67;  4: op = 7'h63;  5, 6: op = 7'h03;
      7: op = 7'h23;  8: op = 7'h13;  9, 10: op = 7'h33;
      default: op = x[6:0];
    endcase
    x[6:0] = op;
    if ($urandom_range(0, 99) < 85) begin
      x[11:7]  = 5'($urandom_range(0, 7));
      x[19:15] = 5'($urandom_range(0, 7));
      x[24:20] = 5'($urandom_range(0, 7));
    end
    if ((op == 7'h33 || op == 7'h13) && $urandom_range(0, 3) < 3)
      x[31:25] = x[31] ? 7'h20 : 7'h00;
    if (op == 7'h67 && x[30]) x[14:12] = 3'b000;
    return x;
  endfunction

  localparam logic [31:0] I_ADDI = 32'hFFF10093;
  localparam logic [31:0] I_LW   = 32'h00032283;
  localparam logic [31:0] I_ADD  = 32'h001283B3;
  localparam logic [31:0] I_ORI  = 32'h05526193;
  localparam logic [31:0] I_ADDE = 32'h00208833;
  localparam logic [31:0] I_SRLB = 32'h42115093;

  initial begin
    dec_t p;
    model_reset();

    // pin the reference decoder with hand-computed values
    p = ref_dec(I_ADDI, 5);
    chk("model.addi.imm", p.imm, 32'hFFFF_FFFF);
    p = ref_dec(32'hFFDFF0EF, 5);
    chk("model.jal.imm", p.imm, 32'hFFFF_FFFC);
    p = ref_dec(32'hFE208CE3, 5);
    chk("model.beq.imm", p.imm, 32'hFFFF_FFF8);
    p = ref_dec(32'hFE20AE23, 5);
    chk("model.sw.imm", p.imm, 32'hFFFF_FFFC);
    p = ref_dec(32'h123452B7, 5);
    chk("model.lui.imm", p.imm, 32'h1234_5000);
    chk("model.lui.rd", 32'(p.rd), 5);

    repeat (3) @(negedge clk);
    chk_zero("reset");
    for (int k = 0; k < N; k++)
      chk($sformatf("reset.u%0d.ins_ready", k), 32'(rdy[k]), 1);
    rst_n = 1'b1;

    step(1, I_ADDI, 0, 1);
    chk("addi.ex_valid", 32'(ev[0]), 1);
    chk("addi.rs1", 32'(r1[0]), 2);
    chk("addi.rs2", 32'(r2[0]), 0);
    chk("addi.rd", 32'(rw[0]), 1);
    chk("addi.imm", im[0], 32'hFFFF_FFFF);
    chk("addi.illegal", 32'(ill[0]), 0);

    step(1, I_LW, 0, 1);
    chk("lw.is_load", 32'(ld[0]), 1);
    step(1, I_ADD, 0, 1);
    chk("lu.stall.ready", 32'(last_rdy[0]), 0);
    chk("lu.stall.bubble", 32'(ev[0]), 0);
    chk("lu.nostall.ready", 32'(last_rdy[1]), 1);
    chk("lu.nostall.rd", 32'(rw[1]), 7);
    step(1, I_ADD, 0, 1);
    chk("lu.add.ready", 32'(last_rdy[0]), 1);
    chk("lu.add.regs", 32'({r1[0], r2[0], rw[0]}),
        32'({5'd5, 5'd1, 5'd7}));

    for (int c = 0; c < 3; c++) begin
      step(1, I_ORI, 0, 0);
      chk("bp.ready", 32'(last_rdy[0]), 0);
      chk("bp.hold", io[0], I_ADD);
    end
    step(1, I_ORI, 0, 1);
    chk("bp.accept", 32'(last_rdy[0]), 1);
    chk("bp.ori.imm", im[0], 32'h55);

    step(1, I_ORI, 1, 0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("flush.u%0d.ready", k), 32'(last_rdy[k]), 1);
      chk($sformatf("flush.u%0d.valid", k), 32'(ev[k]), 0);
    end
    step(0, I_ORI, 0, 1);
    chk("flush.dropped", 32'(ev[0]), 0);

    step(1, I_ADDI, 0, 1);
    step(0, I_ADDI, 0, 1);
    chk("pop.no_push", 32'(ev[0]), 0);

    step(1, I_ADDE, 0, 1);
    chk("rv32e.illegal", 32'(ill[2]), 1);
    chk("rv32e.rd", 32'(rw[2]), 0);
    chk("rv32e.imm", im[2], 0);
    chk("rv32i.rd16", 32'(rw[0]), 16);
    step(1, I_SRLB, 0, 1);
    chk("srli.f7.illegal", 32'(ill[0]), 1);
    chk("srli.f7.illegal.e", 32'(ill[2]), 1);

    step(1, I_ADDI, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(negedge clk);
    ins_valid = 0; flush = 0; ex_ready = 0;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < N; k++)
      chk($sformatf("midreset.u%0d.ready", k), 32'(rdy[k]), 1);

    for (int c = 0; c < 3000; c++) begin
      step(logic'($urandom_range(0, 9) < 8), gen_ins(),
           logic'($urandom_range(0, 15) == 0),
           logic'($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Registered, handshaked instruction-decode stage between IF and EX, replacing the purely combinational decoder.
- Decodes RV32I/RV32E instructions into register read/write addresses, a sign-correct immediate and an illegal-instruction flag.
- Registers the result into a single output slot with valid/ready flow control.
- Inserts one bubble on load-use hazards and discards its contents on a pipeline flush.

Parameters:
XLEN, 32, data/immediate width; also the width of ins_addr_i/ins_addr_o.
REG_ADDR_W, 5, register-address width; 5 = RV32I (x0–x31), 4 = RV32E (x0–x15).
LOAD_USE_STALL, 1, 1 = insert a bubble on load-use; 0 = never stall (EX forwards).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ins_valid_i  in  1  IF holds a valid instruction
ins_ready_o  out  1  stage accepts the instruction this cycle
ins_i  in  32  instruction word
ins_addr_i  in  XLEN  instruction address
flush_i  in  1  kill the held and incoming instructions (branch/jump redirect)
ex_valid_o  out  1  output slot holds a decoded instruction
ex_ready_i  in  1  EX consumes the slot this cycle
ins_o  out  32  registered instruction word
ins_addr_o  out  XLEN  registered instruction address
reg1_rd_addr_o  out  REG_ADDR_W  rs1, or 0 if unused
reg2_rd_addr_o  out  REG_ADDR_W  rs2, or 0 if unused
reg_wr_addr_o  out  REG_ADDR_W  rd, or 0 if no write
imm_o  out  XLEN  decoded immediate
is_load_o  out  1  slot holds a load
illegal_o  out  1  slot holds an illegal/unsupported encoding

Behaviour:
- Reset (rst_n low, asynchronous): every output register clears to 0, including ex_valid_o, illegal_o, is_load_o, imm_o and all addresses. ins_ready_o is combinational; it is 0 only while flush_i is low and a stall/backpressure condition holds.
- Handshake:
  - Slot free when !ex_valid_o || ex_ready_i.
  - ins_ready_o = flush_i || (slot free && !hazard).
  - Transfer = ins_valid_i && ins_ready_o. Latency 1: decode results appear on the cycle after the transfer.
  - While ex_valid_o && !ex_ready_i, all outputs hold stable.
- Hazard (only when LOAD_USE_STALL=1):
  - Condition: ex_valid_o && is_load_o && reg_wr_addr_o != 0 && ex_ready_i && the incoming instruction uses rs1 or rs2 equal to reg_wr_addr_o.
  - Response: ins_ready_o = 0 and ex_valid_o = 0 next cycle (bubble). The instruction is accepted on the following cycle.
  - Exactly one bubble is inserted per load-use pair.
- Flush (highest priority): the next cycle has ex_valid_o = 0. The incoming instruction is consumed (ins_ready_o = 1) and dropped. Flush overrides both hazard and backpressure.
- Pop without push: ex_ready_i with no transfer → ex_valid_o = 0 next cycle.
- Decode rules:
  - I-ALU, JALR, LOAD: imm = sign-extended ins[31:20]. SLTIU/XORI/ORI/ANDI are also sign-extended, per the ISA.
  - Shifts: imm = zero-extended shamt ins[24:20]. funct7 must be 0000000, or 0100000 for SRAI only; otherwise illegal.
  - R-type: legal {funct7, funct3} pairs are exactly the RV32I ten; imm = 0.
  - LUI/AUIPC: imm = {ins[31:12], 12'b0}, rs1 = rs2 = 0.
  - JAL: J-immediate, bit 0 forced to 0.
  - Branch: B-immediate; funct3 010/011 illegal; rd = 0.
  - Store: S-immediate; rd = 0.
  - is_load_o: set only for LB/LH/LW/LBU/LHU; other load funct3 values are illegal.
- Illegal handling: unknown opcode or funct, or (REG_ADDR_W=4) bit 4 set in any used register field → illegal_o = 1, all addresses = 0, imm = 0, is_load_o = 0. The slot is still valid and passes downstream for trap handling.
- Register fields are truncated to REG_ADDR_W after the legality check.

Decomposition:
- Opcode, funct3 and funct7 constants, ZERO_WORD and ZERO_REG_ADDR live in the shared defines.v. Add INS_TYPE_LOAD funct3 codes there if missing.
- Sub-module id_decode: purely combinational ins → {rs1, rs2, rd, imm, uses_rs1, uses_rs2, is_load, illegal}, parametrised by XLEN and REG_ADDR_W.
- id_stage_pipe adds the output register, handshake, hazard and flush logic.

Test Plan:
- Reset mid-stream: assert rst_n=0 while ex_valid_o=1 → all outputs 0 immediately; ins_ready_o=1 after release.
- ADDI x1,x2,-1 (0xFFF10093), ex_ready_i=1 → next cycle ex_valid_o=1, rs1=2, rs2=0, rd=1, imm=0xFFFFFFFF, illegal_o=0.
- LW x5,0(x6) (0x00032283) then ADD x7,x5,x1 (0x001283B3) back-to-back → exactly one cycle with ex_valid_o=0 between them. The ADD then appears with rs1=5, rs2=1, rd=7. With LOAD_USE_STALL=0, no bubble.
- Backpressure: hold ex_ready_i=0 for 3 cycles with ins_valid_i=1 → ins_ready_o=0 and outputs stable; the instruction is accepted the cycle after ex_ready_i returns to 1.
- Flush: flush_i=1 together with a valid incoming ORI → ins_ready_o=1, ex_valid_o=0 next cycle; the ORI never appears.
- REG_ADDR_W=4: ADD x16,x1,x2 (0x00208833) → illegal_o=1, rd=0, imm=0. SRLI with funct7=0100001 → illegal_o=1.
